// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared constants, state type and helpers for score_display
//
// Purpose : seven-segment glyph constants (active-low, bit0=a .. bit6=g),
//           the display FSM state type, a nibble-to-glyph decoder and a
//           constant power-of-ten helper for the decimal overflow limit.
// Ports   : none (package)
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // Elaboration-time only: 10^n for the decimal overflow threshold.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// rtl/score_display_bin2bcd_seq.sv - iterative double-dabble binary-to-BCD converter
//
// Purpose : converts i_bin to packed BCD, one shift per clock, DATA_WIDTH clocks.
// Ports   : i_clk, i_reset (sync, active-high)
//           i_start  - load i_bin and begin a conversion
//           i_bin    - binary value, sampled with i_start
//           o_busy   - conversion iterations in progress
//           o_done   - high during the final iteration; o_bcd is final next cycle
//           o_bcd    - NUM_DIGITS packed BCD digits, digit 0 in [3:0]
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [DATA_WIDTH-1:0]     i_bin,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [NUM_DIGITS*4-1:0]   o_bcd
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0]   r_bin;
  logic [NUM_DIGITS*4-1:0] r_bcd;
  logic [NUM_DIGITS*4-1:0] w_adj;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;

  // Add-3 correction so each nibble carries correctly into the next on shift.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) begin
        w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
      end
    end
  end

  // Digits above NUM_DIGITS fall off the top; the caller flags such values
  // as overflow, so the truncated result is never displayed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= CNT_W'(DATA_WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= {w_adj[NUM_DIGITS*4-2:0], r_bin[DATA_WIDTH-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - multi-source seven-segment display driver
//
// Purpose : picks one of NUM_SRC values, renders it in decimal or hex on
//           NUM_DIGITS active-low digits with leading-zero blanking,
//           overflow dashes and whole-display blinking.
// Ports   : Clock, reset (sync, active-high)
//           src_data - packed sources, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//           src_sel  - source index, out-of-range selects source 0
//           hex_mode - 1 hex, 0 decimal
//           blank_lz - blank leading zeros
//           blink_en - blink the whole display
//           hex_out  - digit d at [d*7 +: 7], active-low
//           overflow - value does not fit in NUM_DIGITS
//           busy     - decimal conversion in progress
//           update   - one-cycle pulse when hex_out takes a new value
module score_display
  import score_display_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 20,
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                                          Clock,
  input  logic                                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]                 src_data,
  input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] src_sel,
  input  logic                                          hex_mode,
  input  logic                                          blank_lz,
  input  logic                                          blink_en,
  output logic [NUM_DIGITS*7-1:0]                       hex_out,
  output logic                                          overflow,
  output logic                                          busy,
  output logic                                          update
);

  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NIB_W   = NUM_DIGITS * 4;
  localparam int SEG_W   = NUM_DIGITS * 7;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [63:0]    DEC_LIMIT = pow10(NUM_DIGITS);
  localparam logic [SEL_W:0] SRC_LIM   = (SEL_W + 1)'(NUM_SRC);

  state_t               r_state;
  logic [NIB_W-1:0]     r_val;
  logic                 r_hex_mode;
  logic                 r_blank_lz;
  logic                 r_ovf_cap;
  logic                 r_ovf;
  logic                 r_update;
  logic [SEG_W-1:0]     r_hex;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_hidden;

  logic [SEL_W-1:0]      w_sel;
  logic [DATA_WIDTH-1:0] w_src_val;
  logic [63:0]           w_src_64;
  logic                  w_ovf;
  logic                  w_conv_start;
  logic                  w_conv_busy;
  logic                  w_conv_done;
  logic [NIB_W-1:0]      w_bcd;
  logic [NIB_W-1:0]      w_nib;
  logic [SEG_W-1:0]      w_digits;
  logic                  w_seen;

  assign w_sel     = ({1'b0, src_sel} < SRC_LIM) ? src_sel : '0;
  assign w_src_val = src_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_src_64  = 64'(w_src_val);
  assign w_ovf     = hex_mode ? ((w_src_64 >> NIB_W) != 64'd0)
                              : (w_src_64 >= DEC_LIMIT);

  // The converter samples the live source in the same LOAD cycle the FSM captures it.
  assign w_conv_start = (r_state == LOAD) && !hex_mode;

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .i_clk   (Clock),
    .i_reset (reset),
    .i_start (w_conv_start),
    .i_bin   (w_src_val),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  // Glyphs from the captured value; scanning from the top digit down lets
  // w_seen mark everything below the most significant nonzero digit.
  always_comb begin
    w_nib    = r_hex_mode ? r_val : w_bcd;
    w_seen   = 1'b0;
    w_digits = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      if (r_ovf_cap) begin
        w_digits[d*7 +: 7] = SEG_DASH;
      end else if (r_blank_lz && !w_seen && (d != 0) && (w_nib[d*4 +: 4] == 4'd0)) begin
        w_digits[d*7 +: 7] = SEG_BLANK;
      end else begin
        w_digits[d*7 +: 7] = hex_to_seg(w_nib[d*4 +: 4]);
      end
      if (w_nib[d*4 +: 4] != 4'd0) begin
        w_seen = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_val      <= '0;
      r_hex_mode <= 1'b0;
      r_blank_lz <= 1'b0;
      r_ovf_cap  <= 1'b0;
      r_ovf      <= 1'b0;
      r_update   <= 1'b0;
      r_hex      <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_update <= 1'b0;
      case (r_state)
        IDLE: r_state <= LOAD;
        LOAD: begin
          r_val      <= w_src_64[NIB_W-1:0];
          r_hex_mode <= hex_mode;
          r_blank_lz <= blank_lz;
          r_ovf_cap  <= w_ovf;
          r_state    <= hex_mode ? DONE : CONV;
        end
        CONV: begin
          if (w_conv_done) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_hex    <= w_digits;
          r_ovf    <= r_ovf_cap;
          r_update <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Free-running blink timebase; independent of blink_en so the phase is
  // already defined when blinking is switched on.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_hidden    <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_hidden    <= ~r_hidden;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign hex_out  = (blink_en && r_hidden) ? {SEG_W{1'b1}} : r_hex;
  assign overflow = r_ovf;
  assign busy     = w_conv_busy;
  assign update   = r_update;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - scoreboard testbench for score_display
module tb_score_display;

  localparam int NS = 3;
  localparam int DW = 20;
  localparam int ND = 6;
  localparam int BD = 4;
  localparam int SW = 2;
  localparam int NT = 40;

  logic              Clock = 1'b0;
  logic              reset = 1'b1;
  logic [NS*DW-1:0]  src_data;
  logic [SW-1:0]     src_sel;
  logic              hex_mode;
  logic              blank_lz;
  logic              blink_en;
  logic [ND*7-1:0]   hex_out;
  logic              overflow;
  logic              busy;
  logic              update;

  score_display #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .NUM_DIGITS (ND),
    .BLINK_DIV  (BD)
  ) dut (
    .Clock    (Clock),
    .reset    (reset),
    .src_data (src_data),
    .src_sel  (src_sel),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .hex_out  (hex_out),
    .overflow (overflow),
    .busy     (busy),
    .update   (update)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [ND*7-1:0] disp;
    bit              ov;
    int              cyc;
  } exp_t;

  exp_t            q[$];
  logic [ND*7-1:0] last_disp = '1;
  int              rst_rel   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: digits by plain division in the chosen base.
  function automatic void model(input int unsigned v, input bit hm, input bit blz,
                                output logic [ND*7-1:0] d, output bit ov);
    int unsigned dig [ND];
    int unsigned base;
    int unsigned p;
    int          ms;
    base = hm ? 16 : 10;
    p    = 1;
    ms   = 0;
    for (int k = 0; k < ND; k++) begin
      dig[k] = (v / p) % base;
      p      = p * base;
    end
    ov = (v >= p);
    for (int k = 0; k < ND; k++) if (dig[k] != 0) ms = k;
    for (int k = 0; k < ND; k++) begin
      if (ov)              d[k*7 +: 7] = 7'h3F;
      else if (blz && k > ms) d[k*7 +: 7] = 7'h7F;
      else                 d[k*7 +: 7] = seg_tab[dig[k]];
    end
  endfunction

  function automatic logic [ND*7-1:0] shown(input logic [ND*7-1:0] d);
    bit hidden;
    hidden = (((cyc - rst_rel) / BD) % 2) == 1;
    return (blink_en && hidden) ? '1 : d;
  endfunction

  task automatic push_expected();
    exp_t        e;
    int          idx;
    int unsigned v;
    idx = (int'(src_sel) < NS) ? int'(src_sel) : 0;
    v   = 32'(src_data[idx*DW +: DW]);
    model(v, hex_mode, blank_lz, e.disp, e.ov);
    e.cyc = cyc + (hex_mode ? 3 : DW + 3);
    q.push_back(e);
  endtask

  task automatic set_src(input int i, input int unsigned v);
    src_data[i*DW +: DW] = DW'(v);
  endtask

  function automatic int unsigned rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 99);
      1:       return $urandom & 32'hFFFFF;
      2:       return $urandom_range(0, 999999);
      default: return $urandom_range(999990, 1000010);
    endcase
  endfunction

  task automatic wait_update();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (update) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_update timeout at cycle %0d", cyc);
  endtask

  // Monitor: pops the scoreboard on each update, otherwise checks the held display.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (!reset) begin
        if (update) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_update at cycle %0d: got update=1 expected none", cyc);
          end else begin
            e = q.pop_front();
            check("update_hex", 64'(hex_out), 64'(shown(e.disp)));
            check("overflow", 64'(overflow), 64'(e.ov));
            check("latency", 64'(cyc), 64'(e.cyc));
            check("busy_at_update", 64'(busy), 64'd0);
            last_disp = e.disp;
          end
        end else begin
          check("hold_hex", 64'(hex_out), 64'(shown(last_disp)));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit perturb;
    bit do_reset;
    src_data = '0;
    src_sel  = '0;
    hex_mode = 1'b0;
    blank_lz = 1'b1;
    blink_en = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_hex", 64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_update", 64'(update), 64'd0);

    set_src(0, 1234);
    reset   = 1'b0;
    rst_rel = cyc;
    push_expected();

    for (int t = 1; t < NT; t++) begin
      wait_update();
      perturb  = 1'b0;
      do_reset = 1'b0;
      case (t)
        1: begin set_src(0, 1048575); end
        2: begin set_src(0, 999999); end
        3: begin hex_mode = 1'b1; set_src(0, 32'hABCDE); end
        4: begin blank_lz = 1'b0; set_src(0, 0); end
        5: begin
          hex_mode = 1'b0; blank_lz = 1'b1;
          set_src(0, 4321); set_src(2, 32'h12345);
          perturb = 1'b1;
        end
        6: ;
        7: begin hex_mode = 1'b0; src_sel = 2'd3; set_src(0, 77); set_src(1, 555); end
        8: begin src_sel = 2'd1; set_src(1, 500000); do_reset = 1'b1; end
        9, 10, 11, 12: begin
          blink_en = 1'b1; hex_mode = (t % 2) == 1; src_sel = 2'd0; set_src(0, rand_val());
        end
        13: begin blink_en = 1'b0; hex_mode = 1'b0; set_src(0, 42); end
        default: begin
          for (int i = 0; i < NS; i++) set_src(i, rand_val());
          src_sel  = SW'($urandom_range(0, 3));
          hex_mode = 1'($urandom_range(0, 1));
          blank_lz = 1'($urandom_range(0, 1));
          blink_en = ($urandom_range(0, 3) == 0);
          perturb  = !hex_mode && ($urandom_range(0, 2) == 0);
        end
      endcase
      push_expected();

      if (perturb) begin
        repeat (4) @(negedge Clock);
        check("busy_mid_conv", 64'(busy), 64'd1);
        if (t == 5) begin
          src_sel  = 2'd2;
          hex_mode = 1'b1;
        end else begin
          src_sel  = SW'($urandom_range(0, 3));
          hex_mode = 1'($urandom_range(0, 1));
          for (int i = 0; i < NS; i++) set_src(i, rand_val());
        end
      end

      if (do_reset) begin
        repeat (4) @(negedge Clock);
        check("busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        q.delete();
        last_disp = '1;
        @(negedge Clock);
        check("reset_hex_blank", 64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_update", 64'(update), 64'd0);
        @(negedge Clock);
        reset   = 1'b0;
        rst_rel = cyc;
        push_expected();
      end
    end

    wait_update();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
